// File: rtl/ta_ldd_seq.sv
// Wavelength-scan sequencer: plays a small table of (wdis, plus) entries as com_open pulses.
// Optional TA_LDD_SEQ_SKIP_ZERO_EN: zero-dwell entries are skipped without an open.
module ta_ldd_seq #(
   parameter int unsigned TOP0_0 = 3,
   parameter int unsigned LDD0_0 = 32,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk200,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [TOP0_0-1:0] cfg_wdis,
   input  logic [LDD0_0-1:0] cfg_plus,
   input  logic [ADDR_W:0]   cfg_len,
   input  logic [15:0]       cfg_gap,
   input  logic [15:0]       cfg_loops,
   input  logic              start,
   input  logic              stop,
   output logic [TOP0_0-1:0] com_wdis,
   output logic [LDD0_0-1:0] com_plus,
   output logic              com_open,
   output logic              com_close,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] entry_idx
);
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned LW    = ADDR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DWELL, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [TOP0_0-1:0] tbl_wdis [DEPTH];
   logic [LDD0_0-1:0] tbl_plus [DEPTH];
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [LW-1:0]     len_q, len_d;
   logic [15:0]       gap_q, gap_d, loops_q, loops_d, loop_q, loop_d;
   logic [LDD0_0-1:0] dcnt_q, dcnt_d;
   logic [15:0]       gcnt_q, gcnt_d;
   logic [TOP0_0-1:0] wdis_d;
   logic [LDD0_0-1:0] plus_d;
   logic [ADDR_W-1:0] eidx_d;
   logic              open_d, close_d, done_d, busy_d;
   logic              adv, last_c, fin_c, skip_c;
   logic [15:0]       loop_inc_c;

   always_comb begin
      last_c     = (LW'(idx_q) + LW'(1)) >= len_q;
      loop_inc_c = loop_q + 16'd1;
      fin_c      = last_c && (loops_q != 16'd0) && (loop_inc_c == loops_q);
`ifdef TA_LDD_SEQ_SKIP_ZERO_EN
      skip_c     = (tbl_plus[idx_q] == '0);
`else
      skip_c     = 1'b0;
`endif
   end

   // Next-state and registered-output values
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      gap_d   = gap_q;
      loops_d = loops_q;
      loop_d  = loop_q;
      dcnt_d  = dcnt_q;
      gcnt_d  = gcnt_q;
      wdis_d  = com_wdis;
      plus_d  = com_plus;
      eidx_d  = entry_idx;
      open_d  = 1'b0;
      close_d = 1'b0;
      done_d  = 1'b0;
      adv     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !stop && (cfg_len != '0)) begin
               len_d   = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
               gap_d   = cfg_gap;
               loops_d = cfg_loops;
               idx_d   = '0;
               loop_d  = 16'd0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (skip_c) begin
               adv = 1'b1;
            end else begin
               open_d  = 1'b1;
               wdis_d  = tbl_wdis[idx_q];
               plus_d  = tbl_plus[idx_q];
               eidx_d  = idx_q;
               dcnt_d  = tbl_plus[idx_q];
               state_d = S_DWELL;
            end
         end
         S_DWELL: begin
            // A zero count never reaches 1, so a zero-dwell entry holds here until stop
            if (dcnt_q == LDD0_0'(1)) begin
               if (gap_q == 16'd0) begin
                  adv = 1'b1;
               end else begin
                  gcnt_d  = gap_q;
                  state_d = S_GAP;
               end
            end else if (dcnt_q != '0) begin
               dcnt_d = dcnt_q - LDD0_0'(1);
            end
         end
         S_GAP: begin
            if (gcnt_q <= 16'd1) adv = 1'b1;
            else                 gcnt_d = gcnt_q - 16'd1;
         end
         default: state_d = S_IDLE;
      endcase

      if (adv) begin
         if (!last_c) begin
            idx_d   = ADDR_W'(idx_q + ADDR_W'(1));
            state_d = S_FETCH;
         end else begin
            idx_d  = '0;
            loop_d = loop_inc_c;
            if (fin_c) begin
               done_d  = 1'b1;
               wdis_d  = '0;
               plus_d  = '0;
               state_d = S_IDLE;
            end else begin
               state_d = S_FETCH;
            end
         end
      end

      // Abort wins over any open or completion in the same cycle
      if (stop && (state_q != S_IDLE)) begin
         open_d  = 1'b0;
         done_d  = 1'b0;
         close_d = 1'b1;
         wdis_d  = '0;
         plus_d  = '0;
         state_d = S_IDLE;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk200) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         len_q     <= '0;
         gap_q     <= 16'd0;
         loops_q   <= 16'd0;
         loop_q    <= 16'd0;
         dcnt_q    <= '0;
         gcnt_q    <= 16'd0;
         com_wdis  <= '0;
         com_plus  <= '0;
         com_open  <= 1'b0;
         com_close <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         entry_idx <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         gap_q     <= gap_d;
         loops_q   <= loops_d;
         loop_q    <= loop_d;
         dcnt_q    <= dcnt_d;
         gcnt_q    <= gcnt_d;
         com_wdis  <= wdis_d;
         com_plus  <= plus_d;
         com_open  <= open_d;
         com_close <= close_d;
         busy      <= busy_d;
         done      <= done_d;
         entry_idx <= eidx_d;
      end
   end

   // Entry table; writes accepted only while idle
   always_ff @(posedge clk200) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            tbl_wdis[i] <= '0;
            tbl_plus[i] <= '0;
         end
      end else if (cfg_we && (state_q == S_IDLE)) begin
         tbl_wdis[cfg_addr] <= cfg_wdis;
         tbl_plus[cfg_addr] <= cfg_plus;
      end
   end
endmodule

// File: tb/tb_ta_ldd_seq.sv
// Directed self-checking bench for ta_ldd_seq (honours TA_LDD_SEQ_SKIP_ZERO_EN).
module tb_ta_ldd_seq;
   localparam int unsigned TW = 3;
   localparam int unsigned PW = 32;
   localparam int unsigned AW = 3;

   logic          clk200 = 1'b0;
   logic          rst, cfg_we, start, stop;
   logic [AW-1:0] cfg_addr;
   logic [TW-1:0] cfg_wdis;
   logic [PW-1:0] cfg_plus;
   logic [AW:0]   cfg_len;
   logic [15:0]   cfg_gap, cfg_loops;
   logic [TW-1:0] com_wdis;
   logic [PW-1:0] com_plus;
   logic          com_open, com_close, busy, done;
   logic [AW-1:0] entry_idx;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk200 = ~clk200;

   ta_ldd_seq #(.TOP0_0(TW), .LDD0_0(PW), .ADDR_W(AW)) dut (
      .clk200(clk200), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdis(cfg_wdis), .cfg_plus(cfg_plus), .cfg_len(cfg_len),
      .cfg_gap(cfg_gap), .cfg_loops(cfg_loops), .start(start), .stop(stop),
      .com_wdis(com_wdis), .com_plus(com_plus), .com_open(com_open),
      .com_close(com_close), .busy(busy), .done(done), .entry_idx(entry_idx)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk200);
         #1;
      end
   endtask

   task automatic wr(input int a, input int w, input int p);
      cfg_we   = 1'b1;
      cfg_addr = AW'(a);
      cfg_wdis = TW'(w);
      cfg_plus = PW'(p);
      tick();
      cfg_we   = 1'b0;
   endtask

   // Sample start once; returns in the FETCH cycle
   task automatic go(input int len, input int gap, input int loops);
      cfg_len   = (AW+1)'(len);
      cfg_gap   = 16'(gap);
      cfg_loops = 16'(loops);
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
      cfg_addr = '0; cfg_wdis = '0; cfg_plus = '0;
      cfg_len = '0; cfg_gap = 16'd0; cfg_loops = 16'd0;
      tick(2);
      chk("rst_open", com_open, 0);
      chk("rst_close", com_close, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wdis", com_wdis, 0);
      chk("rst_plus", com_plus, 0);
      rst = 1'b0;
      tick();

      // Basic scan
      wr(0, 1, 4);
      wr(1, 5, 2);
      go(2, 3, 1);
      chk("basic_fetch_busy", busy, 1);
      chk("basic_fetch_open", com_open, 0);
      tick();
      chk("basic_open0", com_open, 1);
      chk("basic_wdis0", com_wdis, 1);
      chk("basic_plus0", com_plus, 4);
      chk("basic_idx0", entry_idx, 0);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("basic_between", com_open, 0);
      end
      tick();
      chk("basic_open1", com_open, 1);
      chk("basic_wdis1", com_wdis, 5);
      chk("basic_plus1", com_plus, 2);
      chk("basic_idx1", entry_idx, 1);
      for (int i = 1; i < 5; i++) begin
         tick();
         chk("basic_nodone", done, 0);
      end
      tick();
      chk("basic_done", done, 1);
      chk("basic_busy_low", busy, 0);
      chk("basic_wdis_clr", com_wdis, 0);
      chk("basic_plus_clr", com_plus, 0);
      tick();
      chk("basic_done_pulse", done, 0);

      // Zero gap, three loops
      wr(0, 2, 1);
      go(1, 0, 3);
      tick(); chk("zg_open0", com_open, 1); chk("zg_wdis", com_wdis, 2);
      tick(); chk("zg_gap0", com_open, 0);
      tick(); chk("zg_open1", com_open, 1);
      tick(); chk("zg_gap1", com_open, 0);
      tick(); chk("zg_open2", com_open, 1); chk("zg_nodone", done, 0);
      tick(); chk("zg_done", done, 1); chk("zg_busy", busy, 0);

      // Mid-dwell abort
      wr(0, 6, 100);
      go(1, 0, 0);
      tick(); chk("ab_open", com_open, 1); chk("ab_plus", com_plus, 100);
      tick(5);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("ab_close", com_close, 1);
      chk("ab_busy", busy, 0);
      chk("ab_done", done, 0);
      chk("ab_wdis", com_wdis, 0);
      chk("ab_plus_clr", com_plus, 0);
      tick(); chk("ab_close_pulse", com_close, 0);

      // Write while busy is ignored
      wr(0, 1, 4);
      go(2, 0, 1);
      tick(); chk("wb_open0", com_wdis, 1);
      cfg_we = 1'b1; cfg_addr = '0; cfg_wdis = 3'd7; cfg_plus = 32'd9;
      tick();
      cfg_we = 1'b0;
      tick(4); chk("wb_open1", com_open, 1); chk("wb_wdis1", com_wdis, 5);
      tick(2); chk("wb_done", done, 1);
      go(2, 0, 1);
      tick();
      chk("wb_re_open", com_open, 1);
      chk("wb_re_wdis", com_wdis, 1);
      chk("wb_re_plus", com_plus, 4);
      tick(7); chk("wb_re_done", done, 1);

      // Zero-plus entry in the middle
      wr(0, 1, 2);
      wr(1, 3, 0);
      wr(2, 4, 2);
      go(3, 1, 1);
      tick(); chk("zp_open0", com_wdis, 1);
`ifdef TA_LDD_SEQ_SKIP_ZERO_EN
      for (int i = 1; i < 5; i++) begin
         tick();
         chk("zp_skip_noopen", com_open, 0);
      end
      tick(); chk("zp_open2", com_open, 1); chk("zp_wdis2", com_wdis, 4);
      tick(3); chk("zp_done", done, 1);
`else
      tick(4);
      chk("zp_open1", com_open, 1);
      chk("zp_wdis1", com_wdis, 3);
      chk("zp_plus1", com_plus, 0);
      tick(20);
      chk("zp_stall_busy", busy, 1);
      chk("zp_stall_open", com_open, 0);
      chk("zp_stall_plus", com_plus, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("zp_close", com_close, 1);
      chk("zp_close_busy", busy, 0);
`endif

      // Start ignored with zero length, or together with stop
      cfg_len = '0; start = 1'b1;
      tick(); start = 1'b0;
      chk("len0_busy", busy, 0);
      tick(); chk("len0_open", com_open, 0);
      cfg_len = 4'd1; start = 1'b1; stop = 1'b1;
      tick(); start = 1'b0; stop = 1'b0;
      tick(); chk("ss_busy", busy, 0); chk("ss_open", com_open, 0);

      // Reset in GAP clears outputs and table
      wr(0, 1, 2);
      go(1, 5, 0);
      tick(); chk("rs_open", com_open, 1);
      tick(3); chk("rs_busy_gap", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rs_busy", busy, 0);
      chk("rs_wdis", com_wdis, 0);
      chk("rs_plus", com_plus, 0);
      chk("rs_open0", com_open, 0);
      chk("rs_done", done, 0);
      go(1, 0, 1);
      tick();
`ifdef TA_LDD_SEQ_SKIP_ZERO_EN
      chk("rs_tbl_done", done, 1);
      chk("rs_tbl_noopen", com_open, 0);
`else
      chk("rs_tbl_open", com_open, 1);
      chk("rs_tbl_wdis", com_wdis, 0);
      chk("rs_tbl_plus", com_plus, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("rs_tbl_close", com_close, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
